// File: rtl/aes_stream_ctrl.sv
// Bus-master sequencer driving one aes register block: key load, block encrypt/decrypt
// and result readback, bridged to valid/ready block streams.
module aes_stream_ctrl #(
    parameter int POLL_LIMIT = 1024,
    parameter int SETTLE     = 3
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [255:0] key,
    input  logic         keylen,
    input  logic         encdec,
    input  logic         key_load,
    output logic         key_ready,
    input  logic         in_valid,
    input  logic [127:0] in_block,
    output logic         in_ready,
    output logic         out_valid,
    output logic [127:0] out_block,
    input  logic         out_ready,
    output logic         busy,
    output logic         error,
    output logic         aes_cs,
    output logic         aes_we,
    output logic [7:0]   aes_address,
    output logic [31:0]  aes_write_data,
    input  logic [31:0]  aes_read_data
);
    localparam int PW = $clog2(POLL_LIMIT + 1);
    localparam int SW = $clog2(SETTLE + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_CFG, S_KEY, S_INIT, S_KSETTLE, S_KWAIT, S_READY,
        S_BLK, S_NEXT, S_BSETTLE, S_BWAIT, S_RD, S_OUT, S_ERR
    } state_t;

    state_t        state, state_next;
    logic [2:0]    idx, idx_next;
    logic [SW-1:0] settle_cnt, settle_next;
    logic [PW-1:0] poll_cnt, poll_next;
    logic [255:0]  key_r;
    logic [127:0]  blk_r, blk_src;
    logic          cs_d, we_d;
    logic [7:0]    addr_d;
    logic [31:0]   wdata_d;
    logic          unused_read_bits;

    assign unused_read_bits = ^aes_read_data[31:2];

    // Bus registers hold the access belonging to the state being entered, so the
    // read data seen while in a polling/read state answers that state's own access.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state          <= S_IDLE;
            idx            <= '0;
            settle_cnt     <= '0;
            poll_cnt       <= '0;
            key_r          <= '0;
            blk_r          <= '0;
            out_block      <= '0;
            aes_cs         <= 1'b0;
            aes_we         <= 1'b0;
            aes_address    <= '0;
            aes_write_data <= '0;
        end else begin
            state          <= state_next;
            idx            <= idx_next;
            settle_cnt     <= settle_next;
            poll_cnt       <= poll_next;
            aes_cs         <= cs_d;
            aes_we         <= we_d;
            aes_address    <= addr_d;
            aes_write_data <= wdata_d;
            if (state_next == S_CFG)
                key_r <= key;
            if (state == S_READY && state_next == S_BLK)
                blk_r <= in_block;
            if (state == S_RD)
                out_block[127 - 32*int'(idx) -: 32] <= aes_read_data;
        end
    end

    always_comb begin
        state_next  = state;
        idx_next    = idx;
        settle_next = settle_cnt;
        poll_next   = poll_cnt;
        case (state)
            S_IDLE, S_ERR: if (key_load) state_next = S_CFG;
            S_READY: begin
                if (key_load) begin
                    state_next = S_CFG;
                end else if (in_valid) begin
                    state_next = S_BLK;
                    idx_next   = '0;
                end
            end
            S_CFG: begin
                state_next = S_KEY;
                idx_next   = '0;
            end
            S_KEY: begin
                if (idx == 3'd7) state_next = S_INIT;
                else             idx_next   = idx + 3'd1;
            end
            S_INIT: begin
                state_next  = S_KSETTLE;
                settle_next = '0;
            end
            S_KSETTLE: begin
                if (settle_cnt == SW'(SETTLE - 1)) begin
                    state_next = S_KWAIT;
                    poll_next  = '0;
                end else begin
                    settle_next = settle_cnt + 1'b1;
                end
            end
            S_KWAIT: begin
                if (aes_read_data[0])                   state_next = S_READY;
                else if (poll_cnt == PW'(POLL_LIMIT - 1)) state_next = S_ERR;
                else                                    poll_next  = poll_cnt + 1'b1;
            end
            S_BLK: begin
                if (idx == 3'd3) state_next = S_NEXT;
                else             idx_next   = idx + 3'd1;
            end
            S_NEXT: begin
                state_next  = S_BSETTLE;
                settle_next = '0;
            end
            S_BSETTLE: begin
                if (settle_cnt == SW'(SETTLE - 1)) begin
                    state_next = S_BWAIT;
                    poll_next  = '0;
                end else begin
                    settle_next = settle_cnt + 1'b1;
                end
            end
            S_BWAIT: begin
                if (aes_read_data[1:0] == 2'b11) begin
                    state_next = S_RD;
                    idx_next   = '0;
                end else if (poll_cnt == PW'(POLL_LIMIT - 1)) begin
                    state_next = S_ERR;
                end else begin
                    poll_next = poll_cnt + 1'b1;
                end
            end
            S_RD: begin
                if (idx == 3'd3) state_next = S_OUT;
                else             idx_next   = idx + 3'd1;
            end
            S_OUT:   if (out_ready) state_next = S_READY;
            default: state_next = S_IDLE;
        endcase
    end

    // The first block word is written on the accepting edge, before blk_r holds it.
    assign blk_src = (state == S_READY) ? in_block : blk_r;

    always_comb begin
        cs_d    = 1'b0;
        we_d    = 1'b0;
        addr_d  = 8'h00;
        wdata_d = 32'h0;
        case (state_next)
            S_CFG:  begin cs_d = 1'b1; we_d = 1'b1; addr_d = 8'h0a; wdata_d = {30'b0, keylen, encdec}; end
            S_KEY: begin
                cs_d    = 1'b1;
                we_d    = 1'b1;
                addr_d  = 8'h10 + 8'(idx_next);
                wdata_d = key_r[255 - 32*int'(idx_next) -: 32];
            end
            S_INIT: begin cs_d = 1'b1; we_d = 1'b1; addr_d = 8'h08; wdata_d = 32'h1; end
            S_KWAIT, S_BWAIT: begin cs_d = 1'b1; addr_d = 8'h09; end
            S_BLK: begin
                cs_d    = 1'b1;
                we_d    = 1'b1;
                addr_d  = 8'h20 + 8'(idx_next);
                wdata_d = blk_src[127 - 32*int'(idx_next) -: 32];
            end
            S_NEXT: begin cs_d = 1'b1; we_d = 1'b1; addr_d = 8'h08; wdata_d = 32'h2; end
            S_RD:   begin cs_d = 1'b1; addr_d = 8'h30 + 8'(idx_next); end
            default: ;
        endcase
    end

    always_comb begin
        key_ready = 1'b0;
        busy      = 1'b1;
        case (state)
            S_READY, S_BLK, S_NEXT, S_BSETTLE, S_BWAIT, S_RD, S_OUT: key_ready = 1'b1;
            default: ;
        endcase
        if (state == S_IDLE || state == S_READY || state == S_ERR)
            busy = 1'b0;
        in_ready  = (state == S_READY) && !key_load;
        out_valid = (state == S_OUT);
        error     = (state == S_ERR);
    end
endmodule

// File: doc/aes_stream_ctrl.md
Name: aes_stream_ctrl

Overview:
- Bus-master sequencer for the aes register-interface block (cs/we/8-bit address/32-bit data).
- Converts a 256-bit key load request plus a valid/ready stream of 128-bit blocks into the aes register access sequence: config, key, init, poll, block, next, poll, result read.
- Returns results on a valid/ready output stream.
- Sits between the stream fabric and one aes instance. It is the only master on that aes bus.

Parameters:
- POLL_LIMIT, 1024: maximum status reads per wait phase before the error state is entered. Must be ≥ 1.
- SETTLE, 3: idle cycles after each init/next write before status polling starts. Covers the registered init → core ready → status ready pipeline. Must be ≥ 3.

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous, active-low reset
- key  in  256  cipher key; bits [255:224] go to key word 0. AES-128 uses [255:128].
- keylen  in  1  0 = 128-bit key, 1 = 256-bit key
- encdec  in  1  1 = encrypt, 0 = decrypt
- key_load  in  1  single-cycle request to (re)load key, keylen and encdec
- key_ready  out  1  key expansion complete; stream is accepting
- in_valid  in  1  input block valid
- in_block  in  128  input block; bits [127:96] go to block word 0
- in_ready  out  1  controller accepts in_block this cycle
- out_valid  out  1  result valid
- out_block  out  128  result; result word 0 lands in [127:96]
- out_ready  in  1  sink accepts out_block
- busy  out  1  state is not IDLE, READY or ERR
- error  out  1  poll timeout, sticky
- aes_cs  out  1  aes chip select
- aes_we  out  1  aes write enable
- aes_address  out  8  aes register address
- aes_write_data  out  32  aes write data
- aes_read_data  in  32  aes read data, combinational in the same cycle as aes_cs=1, aes_we=0

Behaviour:
- Reset: all state updates on the rising edge of clk. reset_n=0 at an edge forces state=IDLE and zeroes all outputs, internal key/block/result/poll/settle registers. Reset mid-operation abandons the sequence immediately with no bus access that cycle.
- Bus outputs are registered. At most one aes access per cycle. aes_cs=0 in every state not listed as accessing.
- key_load is honoured only in IDLE, READY and ERR; ignored in all other states.
  - On acceptance, key, keylen and encdec are captured into internal registers.
  - error is cleared and the FSM enters CFG.
- CFG (1 cycle): write address 0x0a, data {30'b0, keylen, encdec}.
- KEY (8 cycles): write 0x10..0x17 in order, word i = key[255-32i -: 32].
- INIT (1 cycle): write 0x08, data 0x1.
- KSETTLE: SETTLE cycles, no access.
- KWAIT: read 0x09 every cycle.
  - Exit to READY on bit0=1.
  - If the poll count reaches POLL_LIMIT without bit0=1, go to ERR.
- READY: key_ready=1, in_ready=1, no access.
  - in_valid & in_ready captures in_block and goes to BLK; in_ready is 0 in the following cycle.
  - If key_load and in_valid arrive in the same cycle, key_load wins and the block is not accepted (in_ready is forced 0 that cycle).
- BLK (4 cycles): write 0x20..0x23, word i = block[127-32i -: 32].
- NEXT (1 cycle): write 0x08, data 0x2.
- BSETTLE: SETTLE cycles, no access.
- BWAIT: read 0x09 every cycle.
  - Exit on bit0=1 and bit1=1 in the same read.
  - Timeout rule is the same as KWAIT, with a fresh counter.
- RD (4 cycles): read 0x30..0x33; aes_read_data is captured into out_block[127-32i -: 32].
- OUT: out_valid=1 with out_block held stable until out_ready=1, then return to READY.
  - out_valid and out_block may not change while out_ready=0.
  - No bus access is made while in OUT.
- ERR: error=1, key_ready=0, in_ready=0, no access. Only key_load or reset leaves ERR.
- key_ready=1 in READY, and in BLK through OUT after a successful key load. key_ready=0 in IDLE, CFG..KWAIT and ERR.
- Throughput:
  - Key setup = 10 + SETTLE + poll cycles.
  - Block = 5 + SETTLE + poll + 4 + ≥ 1 output cycle.
  - No overlap of consecutive blocks.

Test Plan:
- Reset: hold reset_n=0 for 3 cycles with random inputs → all outputs 0; after release the FSM stays IDLE with aes_cs=0 until key_load.
- AES-128 encrypt:
  - Stimulus: key[255:128]=000102030405060708090a0b0c0d0e0f, keylen=0, encdec=1, key_load; then block 00112233445566778899aabbccddeeff.
  - Required bus trace: write 0x0a←0x1; writes 0x10..0x17; write 0x08←0x1; 3 idle cycles; polls.
  - Required result: out_block 69c4e0d86a7b0430d8cdb78070b4c55a.
- AES-256 encrypt then decrypt:
  - Encrypt: key 000102…1f, keylen=1, same block → out_block 8ea2b7ca516745bfeafc49904b496089.
  - Decrypt: key_load with encdec=0, feed that result → 00112233445566778899aabbccddeeff.
- Backpressure: hold out_ready=0 for 20 cycles → out_valid and out_block stable, in_ready=0, aes_cs=0. After release, a second block is accepted the next cycle and processed correctly.
- Timeout: aes stub returns 0 on status reads, POLL_LIMIT=16 → exactly 16 reads of 0x09, then error=1, key_ready=0; a subsequent key_load clears error and restarts CFG.
- Sequencing edge cases:
  - key_load pulsed during BWAIT → ignored, result still correct.
  - key_load and in_valid together in READY → block not accepted, key reload happens.
  - reset_n=0 during KEY → IDLE next edge with no further aes access.
